// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game: keypad geometry, key index
// width and the keypad scanner state encoding.
package whack_pkg;

  localparam int KEY_ROWS  = 4;
  localparam int KEY_COLS  = 4;
  localparam int KEY_IDX_W = 4;
  localparam int ROW_W     = $clog2(KEY_ROWS);
  localparam int COL_W     = $clog2(KEY_COLS);

  typedef enum logic [1:0] {
    KS_SCAN     = 2'd0,
    KS_DEBOUNCE = 2'd1,
    KS_HELD     = 2'd2
  } ks_state_e;

  // Key index is row-major: row * KEY_COLS + col.
  function automatic logic [KEY_IDX_W-1:0] key_idx(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the debounced key stream handed to the game logic.
interface keypad_scanner_if;
  import whack_pkg::*;

  logic [KEY_ROWS-1:0]  row_in;
  logic [KEY_COLS-1:0]  col_out;
  logic                 key_en;
  logic [KEY_IDX_W-1:0] key_index;
  logic                 key_held;

  // master: the scanner; slave: keypad pins and key consumers.
  modport master (input row_in, output col_out, key_en, key_index, key_held);
  modport slave  (output row_in, input col_out, key_en, key_index, key_held);
endinterface

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // Next values: first stage captures the pin, second stage the first.
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  // Synchronizer flops, reset to the idle level of the input.
  // NOTE: state flops use <= so every flop samples pre-edge values; blocking
  // here would collapse the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one low column at a time, samples the
// synchronized rows at the end of each column slot, keeps the lowest pressed
// key per full scan and debounces over whole scans. One key_en pulse per
// accepted press, no auto-repeat.
module keypad_scanner
  import whack_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master bus
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(KEY_COLS - 1);

  // Synchronized rows (active-low, idle high).
  logic [KEY_ROWS-1:0] row_sync;

  // Slot timing and column walk.
  logic [SLOT_W-1:0] slot_d, slot_q;
  logic [COL_W-1:0]  col_d, col_q;
  logic [KEY_COLS-1:0] col_out;

  // Per-scan accumulator: lowest active key seen so far in this scan.
  logic                 acc_hit_d, acc_hit_q;
  logic [KEY_IDX_W-1:0] acc_idx_d, acc_idx_q;

  // Debounce FSM and outputs.
  ks_state_e            state_d, state_q;
  logic [KEY_IDX_W-1:0] cand_d, cand_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 key_en_d, key_en_q;
  logic [KEY_IDX_W-1:0] key_index_d, key_index_q;
  logic                 key_held_d, key_held_q;

  // Combinational scan helpers.
  logic                 sample;
  logic                 commit;
  logic                 col_hit;
  logic [KEY_IDX_W-1:0] col_idx;
  logic                 scan_hit;
  logic [KEY_IDX_W-1:0] scan_idx;
  logic [CNT_W-1:0]     cnt_inc;

  sync_2ff #(
    .WIDTH   (KEY_ROWS),
    .RST_VAL ({KEY_ROWS{1'b1}})
  ) u_row_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.row_in),
    .dout (row_sync)
  );

  // Drive exactly one column low.
  always_comb begin
    col_out        = '1;
    col_out[col_q] = 1'b0;
  end

  // Sample point, commit point and lowest active key in the driven column,
  // merged with what the earlier columns of this scan found.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    sample   = (slot_q == SLOT_LAST);
    commit   = sample && (col_q == COL_LAST);
    col_hit  = 1'b0;
    col_idx  = '0;
    // Walk rows high to low so the lowest active row ends up winning.
    for (int r = KEY_ROWS - 1; r >= 0; r--) begin
      if (!row_sync[r]) begin
        col_hit = 1'b1;
        col_idx = key_idx(ROW_W'(r), col_q);
      end
    end
    scan_hit = acc_hit_q | col_hit;
    if (acc_hit_q && (!col_hit || (acc_idx_q < col_idx))) begin
      scan_idx = acc_idx_q;
    end else begin
      scan_idx = col_idx;
    end
  end

  // Slot counter, column advance and scan accumulation.
  always_comb begin
    slot_d    = slot_q + 1'b1;
    col_d     = col_q;
    acc_hit_d = acc_hit_q;
    acc_idx_d = acc_idx_q;
    if (sample) begin
      slot_d = '0;
      col_d  = col_q + 1'b1;
      if (commit) begin
        acc_hit_d = 1'b0;
        acc_idx_d = '0;
      end else begin
        acc_hit_d = scan_hit;
        acc_idx_d = scan_idx;
      end
    end
  end

  // Debounce FSM, stepped once per committed scan.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_en_d    = 1'b0;
    key_index_d = key_index_q;
    key_held_d  = key_held_q;
    cnt_inc     = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;

    if (commit) begin
      unique case (state_q)
        KS_SCAN: begin
          if (scan_hit) begin
            cand_d = scan_idx;
            if (CNT_DONE == CNT_ONE) begin
              key_index_d = scan_idx;
              key_en_d    = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = KS_HELD;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = KS_DEBOUNCE;
            end
          end
        end
        KS_DEBOUNCE: begin
          if (!scan_hit) begin
            cnt_d   = '0;
            state_d = KS_SCAN;
          end else if (scan_idx == cand_q) begin
            if (cnt_inc == CNT_DONE) begin
              key_index_d = cand_q;
              key_en_d    = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = KS_HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // A different key took over: restart the debounce on it.
            cand_d = scan_idx;
            cnt_d  = CNT_ONE;
          end
        end
        KS_HELD: begin
          // Any key keeps the hold alive; a second key is never accepted here.
          if (scan_hit) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_DONE) begin
            cnt_d      = '0;
            key_held_d = 1'b0;
            state_d    = KS_SCAN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = KS_SCAN;
        end
      endcase
    end
  end

  // State register for timing, accumulator, FSM and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= '0;
      col_q       <= '0;
      acc_hit_q   <= 1'b0;
      acc_idx_q   <= '0;
      state_q     <= KS_SCAN;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_en_q    <= 1'b0;
      key_index_q <= '0;
      key_held_q  <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      col_q       <= col_d;
      acc_hit_q   <= acc_hit_d;
      acc_idx_q   <= acc_idx_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_en_q    <= key_en_d;
      key_index_q <= key_index_d;
      key_held_q  <= key_held_d;
    end
  end

  assign bus.col_out   = col_out;
  assign bus.key_en    = key_en_q;
  assign bus.key_index = key_index_q;
  assign bus.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3. A keypad model
// pulls row r low while key (r,c) is down and column c is driven. A scan-level
// reference model predicts every output each cycle; directed scenarios pin
// pulse counts, indices and latency with literal values.
module tb_keypad_scanner;
  import whack_pkg::*;

  localparam int SD = 4;
  localparam int DS = 3;

  logic        clk;
  logic        rst;
  logic [15:0] keys_down;
  logic [3:0]  row_drv;

  int checks = 0;
  int errors = 0;

  keypad_scanner_if intf ();

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a held key shorts its row to its column when driven low.
  always_comb begin
    row_drv = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[4*r+c] && !intf.col_out[c]) row_drv[r] = 1'b0;
  end
  assign intf.row_in = row_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Edge n after reset: column (n/4)%4 is sampled at n%4==3 using the keys
  // that were down two edges earlier. A scan ends with column 3. A press is
  // accepted after DS consecutive scans whose lowest key is the same; a hold
  // ends after DS consecutive empty scans.
  int unsigned m_n;
  logic [15:0] m_k1, m_k2;
  bit          m_acc_hit;
  int          m_acc_idx;
  bit          m_held;
  int          m_run_idx;
  int          m_run_len;
  int          m_c;
  logic        m_en;
  logic [3:0]  m_idx;
  logic [3:0]  m_col;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_k1 = '0; m_k2 = '0;
      m_acc_hit = 0; m_acc_idx = 0;
      m_held = 0; m_run_idx = 0; m_run_len = 0;
      m_en = 1'b0; m_idx = '0; m_col = 4'b1110;
    end else begin
      m_en = 1'b0;
      if (m_n % SD == SD - 1) begin
        m_c = (m_n / SD) % 4;
        for (int r = 0; r < 4; r++)
          if (m_k2[4*r+m_c] && (!m_acc_hit || (4*r+m_c) < m_acc_idx)) begin
            m_acc_hit = 1; m_acc_idx = 4*r+m_c;
          end
        if (m_c == 3) begin
          if (!m_held) begin
            if (m_acc_hit) begin
              if (m_run_len > 0 && m_acc_idx == m_run_idx) m_run_len++;
              else begin m_run_idx = m_acc_idx; m_run_len = 1; end
              if (m_run_len == DS) begin
                m_en = 1'b1; m_idx = 4'(m_run_idx); m_held = 1; m_run_len = 0;
              end
            end else m_run_len = 0;
          end else begin
            if (m_acc_hit) m_run_len = 0;
            else begin
              m_run_len++;
              if (m_run_len == DS) begin m_held = 0; m_run_len = 0; end
            end
          end
          m_acc_hit = 0; m_acc_idx = 0;
        end
      end
      m_k2 = m_k1;
      m_k1 = keys_down;
      m_n++;
      m_col = ~(4'b0001 << ((m_n / SD) % 4));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("col_out", 32'(intf.col_out), 32'(m_col));
    check("key_en", 32'(intf.key_en), 32'(m_en));
    check("key_held", 32'(intf.key_held), 32'(m_held));
    check("key_index", 32'(intf.key_index), 32'(m_idx));
  end

  // Pulse monitor.
  int         en_total = 0;
  logic [3:0] en_last_idx = '0;
  always @(negedge clk) begin
    if (intf.key_en) begin
      en_total++;
      en_last_idx = intf.key_index;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  logic [3:0] col_tbl [16] = '{4'b1110, 4'b1110, 4'b1110,
                               4'b1101, 4'b1101, 4'b1101, 4'b1101,
                               4'b1011, 4'b1011, 4'b1011, 4'b1011,
                               4'b0111, 4'b0111, 4'b0111, 4'b0111,
                               4'b1110};
  int base;
  int first_k;

  initial begin
    keys_down = '0;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(6);

    // 1: asynchronous reset mid-slot, then column walk
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_col_out", 32'(intf.col_out), 32'(4'b1110));
    check("rst_key_en", 32'(intf.key_en), 0);
    check("rst_key_index", 32'(intf.key_index), 0);
    check("rst_key_held", 32'(intf.key_held), 0);
    cycles(2);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("col_walk", 32'(intf.col_out), 32'(col_tbl[k]));
    end
    cycles(1);

    // 2: key 6 held 200 cycles, then released
    keys_down[6] = 1'b1;
    base = en_total;
    cycles(200);
    check("k6_pulses", 32'(en_total - base), 1);
    check("k6_index", 32'(en_last_idx), 6);
    check("k6_held", 32'(intf.key_held), 1);
    keys_down[6] = 1'b0;
    base = en_total;
    cycles(20);
    check("k6_held_early", 32'(intf.key_held), 1);
    cycles(80);
    check("k6_released", 32'(intf.key_held), 0);
    check("k6_no_repeat", 32'(en_total - base), 0);

    // 3: key 9 bouncing every 5 cycles for 60 cycles, then stable
    base = en_total;
    for (int i = 0; i < 12; i++) begin
      keys_down[9] = (i % 2 == 0);
      cycles(5);
    end
    check("k9_bounce_quiet", 32'(en_total - base), 0);
    keys_down[9] = 1'b1;
    cycles(100);
    check("k9_pulses", 32'(en_total - base), 1);
    check("k9_index", 32'(en_last_idx), 9);
    keys_down[9] = 1'b0;
    cycles(100);
    check("k9_released", 32'(intf.key_held), 0);

    // 4: keys 3 and 12 together, lowest wins; 12 alone while held is ignored
    keys_down[3] = 1'b1;
    keys_down[12] = 1'b1;
    base = en_total;
    cycles(100);
    check("k3_12_pulses", 32'(en_total - base), 1);
    check("k3_12_index", 32'(en_last_idx), 3);
    keys_down[3] = 1'b0;
    base = en_total;
    cycles(100);
    check("k12_ignored", 32'(en_total - base), 0);
    check("k12_still_held", 32'(intf.key_held), 1);
    keys_down[12] = 1'b0;
    cycles(100);
    check("k12_released", 32'(intf.key_held), 0);
    keys_down[12] = 1'b1;
    base = en_total;
    cycles(100);
    check("k12_pulses", 32'(en_total - base), 1);
    check("k12_index", 32'(en_last_idx), 12);
    keys_down[12] = 1'b0;
    cycles(100);

    // 5: key 15 glitch for under 2 scans
    keys_down[15] = 1'b1;
    base = en_total;
    cycles(30);
    keys_down[15] = 1'b0;
    cycles(100);
    check("k15_no_pulse", 32'(en_total - base), 0);
    check("k15_index_kept", 32'(intf.key_index), 12);

    // 6: reset while key 0 is held
    keys_down[0] = 1'b1;
    base = en_total;
    cycles(100);
    check("k0_pulses", 32'(en_total - base), 1);
    check("k0_held", 32'(intf.key_held), 1);
    base = en_total;
    rst = 1'b1;
    #1;
    check("k0_rst_held", 32'(intf.key_held), 0);
    check("k0_rst_en", 32'(intf.key_en), 0);
    cycles(3);
    rst = 1'b0;
    first_k = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (intf.key_en && first_k < 0) first_k = k;
    end
    #1;
    check("k0_latency", 32'(first_k), 47);
    check("k0_repulses", 32'(en_total - base), 1);
    check("k0_index", 32'(en_last_idx), 0);
    keys_down[0] = 1'b0;
    cycles(100);
    check("k0_released", 32'(intf.key_held), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
